ofm_axi_wr_master: RTL
======================

// Module: ofm_axi_wr_master
// PURPOSE
//  AXI4 write master directly downstream of the conv engine's OFM flattener. Takes the
//  512-bit OFM AXI-stream plus a level transfer request with target address and byte size.
//  Writes the stream to global memory as INCR bursts that never cross a 4 KB boundary.
//  Reports completion with xfer_done and clears the upstream request with req_clear.
// PARAMETERS
//  DATA_WIDTH   512  AXI/stream data width in bits; beat = DATA_WIDTH/8 = 64 bytes
//  ADDR_WIDTH   64   AXI address width
//  BURST_LEN    16   maximum beats per AW burst (1..256)
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    reset, asynchronous, active-low
//  xfer_req       in   1    level request, held until req_clear
//  xfer_addr      in   64   start byte address, 64 B aligned
//  xfer_size      in   64   byte count, multiple of 64
//  req_clear      out  1    1-cycle pulse, request accepted
//  xfer_done      out  1    1-cycle pulse, last B response received
//  xfer_err       out  1    sticky, any BRESP!=OKAY; cleared at next accept
//  s_axis_tvalid  in   1    OFM stream valid
//  s_axis_tready  out  1    OFM stream ready
//  s_axis_tdata   in   512  OFM stream data
//  m_axi_awvalid/awready  out/in 1;  m_axi_awaddr out 64;  m_axi_awlen out 8
//  m_axi_awsize   out  3    constant 3'b110;  m_axi_awburst out 2 constant 2'b01 (INCR)
//  m_axi_wvalid/wready    out/in 1;  m_axi_wdata out 512;  m_axi_wstrb out 64 all ones
//  m_axi_wlast    out  1    last beat of the current burst
//  m_axi_bvalid   in   1;   m_axi_bready out 1;   m_axi_bresp in 2
// BEHAVIOUR
//  Reset: every valid/ready/pulse output is 0; awaddr=0, awlen=0; xfer_err=0; FSM=IDLE.
//  FSM: IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE.
//  IDLE: when xfer_req=1, latch addr and beats=size>>6, pulse req_clear, clear xfer_err.
//   Next state is AW. If beats==0, go to DONE instead and issue no AW.
//  AW: awvalid=1. awlen+1 = min(remaining beats, BURST_LEN, (4096-addr[11:0])>>6).
//   The address and length are registered and stay stable until awready.
//   On awvalid&awready, go to W with beat counter = awlen.
//  W: wvalid = s_axis_tvalid; s_axis_tready = m_axi_wready; wdata = tdata (combinational pass).
//   wlast is asserted when beat counter==0. On the wlast handshake, go to B.
//   tready=0 in every state other than W. The stream is never consumed outside a burst.
//  B: bready=1. On bvalid, OR (bresp!=0) into xfer_err. Advance addr by (awlen+1)*64 and
//   subtract awlen+1 from remaining beats. If remaining is nonzero go to AW, else go to DONE.
//  DONE: xfer_done pulses for 1 cycle, then IDLE. A new request is accepted no earlier than
//   the cycle after DONE.
//  One burst is outstanding at a time. AW is never issued before the previous B is received.
//  Backpressure: stalls on wready or tvalid hold the beat counter; there is no data buffering.
//  xfer_req is ignored outside IDLE. Once latched, changes to xfer_addr/xfer_size are ignored.
//  Arithmetic: remaining beats are 58 bits and the boundary term is 7 bits. Burst length is
//   clamped so that awlen never exceeds BURST_LEN-1.
//  Reset mid-transfer: all state is discarded and outputs go to reset values immediately.
//   The interconnect is reset together with this block.
// STRUCTURE
//  Shared package: FSM state encodings, AXI_BURST_INCR, AXI_SIZE_64B, BEAT_BYTES=64,
//   PAGE_BYTES=4096.
//  One sub-module: wr_burst_calc, a combinational min() of remaining/BURST_LEN/page boundary.
//   Its output is registered in the parent.
// TESTING
//  1 addr=0x1000 size=256, always ready -> one AW len=3 at 0x1000, 4 W beats with wlast on
//    beat 4, one B, then a single xfer_done pulse.
//  2 size=20*64, BURST_LEN=16 -> AW 0x0 len=15, then AW 0x400 len=3; 20 beats total;
//    stream data matches wdata in order.
//  3 addr=0x0FC0 size=128 -> AW 0x0FC0 len=0, then AW 0x1000 len=0; no burst crosses 4 KB.
//  4 wready toggled 1-of-3 and tvalid gaps inserted -> every beat transferred exactly once,
//    and awaddr/awlen stay stable while awready=0.
//  5 bresp=2'b10 on the first of two bursts -> xfer_err=1 through DONE; cleared on the next
//    accept. size=0 -> req_clear, then xfer_done with no AW issued.
//  6 rst_n asserted mid-W -> all outputs zero asynchronously; after release, a fresh request
//    completes normally.

Source files
------------

// File: rtl/ofm_axi_wr_master_pkg.sv
// Shared definitions for the OFM AXI4 write master: FSM encoding and AXI/page constants.
package ofm_axi_wr_master_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAw,
      StW,
      StB,
      StDone
   } wr_state_e;

   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [2:0]  AXI_SIZE_64B   = 3'b110;
   localparam int unsigned BEAT_BYTES     = 64;
   localparam int unsigned PAGE_BYTES     = 4096;
   localparam int unsigned PAGE_BEATS     = PAGE_BYTES / BEAT_BYTES;
   localparam int unsigned REM_W          = 58;

endpackage

// File: rtl/ofm_axi_wr_master_wr_burst_calc.sv
// Burst sizing: awlen = min(remaining beats, BURST_LEN, beats left in the 4 KB page) - 1.
module wr_burst_calc
   import ofm_axi_wr_master_pkg::*;
#(
   parameter int unsigned BURST_LEN = 16
) (
   input  logic [REM_W-1:0] remaining,
   input  logic [5:0]       page_beat,
   output logic [7:0]       awlen
);

   localparam logic [8:0] MaxBeats = 9'(BURST_LEN);

   logic [6:0] page_room;
   logic [8:0] cap;
   logic [8:0] beats;

   always_comb begin
      // page_beat is addr[11:6], so the room is 1..64 beats
      page_room = 7'(PAGE_BEATS) - {1'b0, page_beat};
      cap       = ({2'b00, page_room} < MaxBeats) ? {2'b00, page_room} : MaxBeats;
      beats     = (remaining < {49'b0, cap}) ? remaining[8:0] : cap;
      awlen     = 8'(beats - 9'd1);
   end

endmodule

// File: rtl/ofm_axi_wr_master.sv
// AXI4 write master: streams the OFM AXI-stream to memory as INCR bursts split at 4 KB pages.
module ofm_axi_wr_master
   import ofm_axi_wr_master_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned BURST_LEN  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    xfer_req,
   input  logic [ADDR_WIDTH-1:0]   xfer_addr,
   input  logic [63:0]             xfer_size,
   output logic                    req_clear,
   output logic                    xfer_done,
   output logic                    xfer_err,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp
);

   wr_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [REM_W-1:0]      rem_q, rem_d;
   logic [7:0]            beat_q, beat_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [7:0]            awlen_q, awlen_d;
   logic [7:0]            calc_awlen;
   logic [8:0]            awlen_p1;
   logic                  unused_size_lsb;

   assign unused_size_lsb = ^xfer_size[5:0];
   assign awlen_p1        = {1'b0, awlen_q} + 9'd1;

   wr_burst_calc #(
      .BURST_LEN(BURST_LEN)
   ) u_burst_calc (
      .remaining(rem_d),
      .page_beat(addr_d[11:6]),
      .awlen    (calc_awlen)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         rem_q    <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
         awaddr_q <= '0;
         awlen_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
         awaddr_q <= awaddr_d;
         awlen_q  <= awlen_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      rem_d         = rem_q;
      beat_d        = beat_q;
      err_d         = err_q;
      req_clear     = 1'b0;
      xfer_done     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      s_axis_tready = 1'b0;
      m_axi_bready  = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_clear = xfer_req;
            if (xfer_req) begin
               addr_d  = xfer_addr;
               rem_d   = xfer_size[63:6];
               err_d   = 1'b0;
               state_d = (rem_d == '0) ? StDone : StAw;
            end
         end
         StAw: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) begin
               beat_d  = awlen_q;
               state_d = StW;
            end
         end
         StW: begin
            // Straight pass-through: the stream only moves when W does
            m_axi_wvalid  = s_axis_tvalid;
            s_axis_tready = m_axi_wready;
            m_axi_wlast   = (beat_q == 8'd0);
            if (s_axis_tvalid && m_axi_wready) begin
               if (beat_q == 8'd0) begin
                  state_d = StB;
               end else begin
                  beat_d = beat_q - 8'd1;
               end
            end
         end
         StB: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               err_d   = err_q | (m_axi_bresp != 2'b00);
               addr_d  = addr_q + ADDR_WIDTH'({awlen_p1, 6'b0});
               rem_d   = rem_q - REM_W'(awlen_p1);
               state_d = (rem_d != '0) ? StAw : StDone;
            end
         end
         StDone: begin
            xfer_done = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Burst address/length are captured on entry to AW and held until awready
   always_comb begin
      awaddr_d = awaddr_q;
      awlen_d  = awlen_q;
      if (state_d == StAw && state_q != StAw) begin
         awaddr_d = addr_d;
         awlen_d  = calc_awlen;
      end
   end

   assign xfer_err      = err_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = awlen_q;
   assign m_axi_awsize  = AXI_SIZE_64B;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_wdata   = s_axis_tdata;
   assign m_axi_wstrb   = '1;

endmodule
